simd_decode_queue: RTL and testbench
====================================

Name: simd_decode_queue

Overview:
- Parametrised successor to the single-entry SIMD32 decode front-end.
- Accepts a stream of tagged 32-bit instruction dwords from fetch and assembles 32- and 64-bit encodings.
- Classifies each assembled instruction into one of eight format classes and buffers up to DEPTH decoded entries.
- Issues those entries to the instruction controller (EX1) over valid/ready. This decouples fetch from EX1 backpressure and removes the one-deep stall coupling of the previous decoder.

Parameters:
- WAVEFRONT_WIDTH, 5, width of the wavefront tag.
- DEPTH, 4, decoded-entry FIFO depth; power of two, minimum 2.
- NUM_FMT, 8, number of format classes; fixed at 8 in this generation.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the queue and the assembly register.
- in_valid  in  1  fetch dword valid.
- in_ready  out  1  dword accepted when in_valid && in_ready.
- in_dword  in  32  instruction dword.
- in_wf  in  WAVEFRONT_WIDTH  wavefront tag of in_dword.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EX1 ready; entry pops when out_valid && out_ready.
- out_inst  out  64  assembled instruction; [63:32]=0 for 32-bit encodings.
- out_wf  out  WAVEFRONT_WIDTH  wavefront tag of the entry.
- out_fmt  out  NUM_FMT  one-hot format, bit order {vector,scalar,flat,ds,export,mimg,mbuf,smem} from bit7 down to bit0.
- out_len64  out  1  entry is a 64-bit encoding.
- out_illegal  out  1  unrecognised encoding; out_fmt=0.
- err_frag  out  1  one-cycle pulse when a pending first dword is discarded.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, reset_n=0): FIFO empty; hold register invalid. All outputs are 0 except in_ready=1.
- Classification uses in_dword[31:26] of a first dword:
  - 0xxxxx: vector, 32-bit.
  - 10xxxx: scalar, 32-bit.
  - 110101: vector (VOP3), 64-bit.
  - 110111: flat, 64-bit.
  - 110110: ds, 64-bit.
  - 111110: export, 64-bit.
  - 111100: mimg, 64-bit.
  - 111000: mbuf, 64-bit.
  - 111101: smem, 64-bit.
  - anything else: illegal, 32-bit.
- Literal-constant dwords are out of scope for this generation.
- in_ready = (count < DEPTH) && !flush. in_ready has no combinational dependence on out_ready.
- First dword of a 32-bit class: pushed in the accept cycle.
- First dword of a 64-bit class: latched in the hold register together with its tag; nothing is pushed.
- Second dword: push {in_dword, hold} in the accept cycle if in_wf equals the held tag. Otherwise:
  - drop the hold contents and pulse err_frag in the next cycle;
  - reclassify the new dword as a first dword.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. A push into an empty FIFO raises out_valid in N+1; there is no combinational bypass.
- Outputs are driven from the head register; they hold stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged. This is legal at count=DEPTH only if in_ready was high, so it cannot occur at full. At count=DEPTH-1 a simultaneous push and pop is allowed.
- Pointers wrap modulo DEPTH. count tracks 0..DEPTH inclusive.
- flush has priority over push and pop in the same cycle:
  - next cycle count=0, out_valid=0, hold invalid, no err_frag;
  - the input dword is not accepted, because in_ready is 0 during flush.
- reset_n asserted mid-operation: everything clears immediately and asynchronously. Outputs return to their reset values.

Decomposition:
- decode_pkg holds: fmt_e enum and FMT_* bit indices; the localparam opcode prefixes; a function fmt_classify(dword) returning {fmt one-hot, len64, illegal}; the typedef dec_entry_t {inst[63:0], wf, fmt, len64, illegal}.
- Sub-module decode_entry_fifo: generic DEPTH-deep dec_entry_t FIFO with push/pop/flush/count, async active-low reset.
- The top level contains the assembly state machine with states FIRST and SECOND, plus the classification logic.

Test Plan:
- 32-bit push: in_dword=0x7E000200, wf=3 at cycle 0 -> cycle 1: out_valid=1, out_fmt=0x80, out_len64=0, out_inst=0x0000_0000_7E00_0200, out_wf=3.
- 64-bit assembly: dwords 0xDC500000 then 0x007D0001 (wf=2, back-to-back) -> one entry: out_fmt=0x20 (flat), out_len64=1, out_inst=0x007D0001_DC500000; no entry after the first dword.
- Fragment error: 0xF4000000 (wf=1), then 0xBE800080 (wf=4) -> err_frag pulses once; single entry with scalar fmt=0x40, wf=4, inst=0xBE800080.
- Backpressure and full: out_ready=0 with 5 scalar dwords offered, DEPTH=4 -> 4 accepted, count=4, in_ready=0; raise out_ready -> entries drain in order, in_ready=1 the cycle after the first pop.
- Illegal and flush: 0xE8000000 -> out_illegal=1, out_fmt=0. Then flush with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, offered dword not accepted.
- Async reset mid-assembly: reset_n low with the hold register valid and count=2 -> all outputs at reset values immediately. After release, a 32-bit dword is decoded as a first dword.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and opcode classification for the SIMD decode queue.
// Format indices, opcode prefixes and the decoded entry bundle.
package decode_pkg;

  localparam int WF_W = 5;

  typedef enum logic [2:0] {
    FMT_SMEM   = 3'd0,
    FMT_MBUF   = 3'd1,
    FMT_MIMG   = 3'd2,
    FMT_EXPORT = 3'd3,
    FMT_DS     = 3'd4,
    FMT_FLAT   = 3'd5,
    FMT_SCALAR = 3'd6,
    FMT_VECTOR = 3'd7
  } fmt_e;

  localparam logic [5:0] OP_VOP3 = 6'b110101;
  localparam logic [5:0] OP_FLAT = 6'b110111;
  localparam logic [5:0] OP_DS   = 6'b110110;
  localparam logic [5:0] OP_EXP  = 6'b111110;
  localparam logic [5:0] OP_MIMG = 6'b111100;
  localparam logic [5:0] OP_MBUF = 6'b111000;
  localparam logic [5:0] OP_SMEM = 6'b111101;

  typedef struct packed {
    logic [7:0] fmt;
    logic       len64;
    logic       illegal;
  } fmt_cls_t;

  typedef struct packed {
    logic [63:0]     inst;
    logic [WF_W-1:0] wf;
    logic [7:0]      fmt;
    logic            len64;
    logic            illegal;
  } dec_entry_t;

  function automatic fmt_cls_t fmt_classify(
    input logic [31:0] dword
  );
    logic [5:0] op;
    fmt_cls_t   c;
    op = dword[31:26];
    c  = '0;
    unique case (1'b1)
      !op[5]: c.fmt[FMT_VECTOR] = 1'b1;
      (op[5:4] == 2'b10): c.fmt[FMT_SCALAR] = 1'b1;
      (op == OP_VOP3): begin
        c.fmt[FMT_VECTOR] = 1'b1;
        c.len64 = 1'b1;
      end
      (op == OP_FLAT): begin
        c.fmt[FMT_FLAT] = 1'b1;
        c.len64 = 1'b1;
      end
      (op == OP_DS): begin
        c.fmt[FMT_DS] = 1'b1;
        c.len64 = 1'b1;
      end
      (op == OP_EXP): begin
        c.fmt[FMT_EXPORT] = 1'b1;
        c.len64 = 1'b1;
      end
      (op == OP_MIMG): begin
        c.fmt[FMT_MIMG] = 1'b1;
        c.len64 = 1'b1;
      end
      (op == OP_MBUF): begin
        c.fmt[FMT_MBUF] = 1'b1;
        c.len64 = 1'b1;
      end
      (op == OP_SMEM): begin
        c.fmt[FMT_SMEM] = 1'b1;
        c.len64 = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_entry_fifo.sv
// Generic DEPTH-deep FIFO of decoded entries.
// Head is read straight from storage; flush clears pointers and count.
module decode_entry_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = dec_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/simd_decode_queue.sv
// Dword assembly, format classification and decoded-entry queue
// between fetch and EX1.
module simd_decode_queue
  import decode_pkg::*;
#(
  parameter int WAVEFRONT_WIDTH = 5,
  parameter int DEPTH           = 4,
  parameter int NUM_FMT         = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_dword,
  input  logic [WAVEFRONT_WIDTH-1:0]  in_wf,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [63:0]                 out_inst,
  output logic [WAVEFRONT_WIDTH-1:0]  out_wf,
  output logic [NUM_FMT-1:0]          out_fmt,
  output logic                        out_len64,
  output logic                        out_illegal,
  output logic                        err_frag,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0]                inst;
    logic [WAVEFRONT_WIDTH-1:0] wf;
    logic [NUM_FMT-1:0]         fmt;
    logic                       len64;
    logic                       illegal;
  } entry_t;

  typedef enum logic {
    FIRST,
    SECOND
  } asm_state_e;

  asm_state_e                  state;
  asm_state_e                  state_d;
  logic [31:0]                 hold_dword;
  logic [WAVEFRONT_WIDTH-1:0]  hold_wf;
  logic                        frag_d;
  logic                        latch;
  logic                        push;
  logic                        pop;
  logic                        accept;
  logic                        empty;
  logic                        full;
  logic [CW-1:0]               cnt;
  entry_t                      din;
  entry_t                      head;
  fmt_cls_t                    cls_in;
  fmt_cls_t                    cls_hold;

  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;
  assign cls_in   = fmt_classify(in_dword);
  assign cls_hold = fmt_classify(hold_dword);

  always_comb begin
    state_d = state;
    frag_d  = 1'b0;
    latch   = 1'b0;
    push    = 1'b0;
    din     = '0;
    if (accept) begin
      if (state == SECOND && in_wf == hold_wf) begin
        push        = 1'b1;
        din.inst    = {in_dword, hold_dword};
        din.wf      = hold_wf;
        din.fmt     = NUM_FMT'(cls_hold.fmt);
        din.len64   = cls_hold.len64;
        din.illegal = cls_hold.illegal;
        state_d     = FIRST;
      end else begin
        // Tag mismatch drops the fragment; the new dword starts afresh
        frag_d = (state == SECOND);
        if (cls_in.len64) begin
          latch   = 1'b1;
          state_d = SECOND;
        end else begin
          push        = 1'b1;
          din.inst    = {32'h0, in_dword};
          din.wf      = in_wf;
          din.fmt     = NUM_FMT'(cls_in.fmt);
          din.len64   = 1'b0;
          din.illegal = cls_in.illegal;
          state_d     = FIRST;
        end
      end
    end
    if (flush) begin
      state_d = FIRST;
      frag_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FIRST;
      hold_dword <= '0;
      hold_wf    <= '0;
      err_frag   <= 1'b0;
    end else begin
      state    <= state_d;
      err_frag <= frag_d;
      if (latch) begin
        hold_dword <= in_dword;
        hold_wf    <= in_wf;
      end
    end
  end

  decode_entry_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (head),
    .empty   (empty),
    .full    (full),
    .count   (cnt)
  );

  assign pop         = out_valid && out_ready;
  assign count       = cnt;
  assign out_valid   = !empty;
  assign out_inst    = out_valid ? head.inst : '0;
  assign out_wf      = out_valid ? head.wf : '0;
  assign out_fmt     = out_valid ? head.fmt : '0;
  assign out_len64   = out_valid && head.len64;
  assign out_illegal = out_valid && head.illegal;

endmodule

// File: tb/tb_simd_decode_queue.sv
// Directed bench for simd_decode_queue.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_simd_decode_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dword;
  logic [4:0]  in_wf;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_inst;
  logic [4:0]  out_wf;
  logic [7:0]  out_fmt;
  logic        out_len64;
  logic        out_illegal;
  logic        err_frag;
  logic [2:0]  count;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simd_decode_queue #(
    .WAVEFRONT_WIDTH (5),
    .DEPTH           (4),
    .NUM_FMT         (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dword    (in_dword),
    .in_wf       (in_wf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_wf      (out_wf),
    .out_fmt     (out_fmt),
    .out_len64   (out_len64),
    .out_illegal (out_illegal),
    .err_frag    (err_frag),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".count"}, 64'(count), 64'd0);
    chk({tag, ".err_frag"}, 64'(err_frag), 64'd0);
    chk({tag, ".out_inst"}, out_inst, 64'd0);
    chk({tag, ".out_fmt"}, 64'(out_fmt), 64'd0);
    chk({tag, ".out_wf"}, 64'(out_wf), 64'd0);
    chk({tag, ".len_ill"}, 64'({out_len64, out_illegal}), 64'd0);
  endtask

  task automatic offer(input logic [31:0] d, input logic [4:0] w);
    in_valid = 1'b1;
    in_dword = d;
    in_wf    = w;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_dword  = '0;
    in_wf     = '0;
    out_ready = 1'b0;
    #2;
    chk_idle("reset");
    step();
    reset_n = 1'b1;
    step();

    // 32-bit vector
    offer(32'h7E00_0200, 5'd3);
    chk("v32.valid", 64'(out_valid), 64'd1);
    chk("v32.fmt", 64'(out_fmt), 64'h80);
    chk("v32.len64", 64'(out_len64), 64'd0);
    chk("v32.inst", out_inst, 64'h0000_0000_7E00_0200);
    chk("v32.wf", 64'(out_wf), 64'd3);
    chk("v32.count", 64'(count), 64'd1);
    step();
    chk("v32.hold", out_inst, 64'h0000_0000_7E00_0200);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("v32.popped", 64'(out_valid), 64'd0);

    // 64-bit flat assembly
    offer(32'hDC50_0000, 5'd2);
    chk("f64.first.count", 64'(count), 64'd0);
    chk("f64.first.valid", 64'(out_valid), 64'd0);
    offer(32'h007D_0001, 5'd2);
    chk("f64.count", 64'(count), 64'd1);
    chk("f64.fmt", 64'(out_fmt), 64'h20);
    chk("f64.len64", 64'(out_len64), 64'd1);
    chk("f64.inst", out_inst, 64'h007D_0001_DC50_0000);
    chk("f64.wf", 64'(out_wf), 64'd2);
    chk("f64.frag", 64'(err_frag), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // fragment error
    offer(32'hF400_0000, 5'd1);
    chk("frag.first.count", 64'(count), 64'd0);
    offer(32'hBE80_0080, 5'd4);
    chk("frag.pulse", 64'(err_frag), 64'd1);
    chk("frag.count", 64'(count), 64'd1);
    chk("frag.fmt", 64'(out_fmt), 64'h40);
    chk("frag.wf", 64'(out_wf), 64'd4);
    chk("frag.inst", out_inst, 64'h0000_0000_BE80_0080);
    chk("frag.len64", 64'(out_len64), 64'd0);
    step();
    chk("frag.once", 64'(err_frag), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("frag.drained", 64'(count), 64'd0);

    // backpressure up to full
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_dword = 32'h8000_0000 + 32'(i);
      in_wf    = 5'(i);
      chk($sformatf("bp.in_ready%0d", i), 64'(in_ready),
          (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    chk("bp.count", 64'(count), 64'd4);
    chk("bp.full", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp.head%0d", i), out_inst,
          64'h8000_0000 + 64'(i));
      chk($sformatf("bp.wf%0d", i), 64'(out_wf), 64'(i));
      step();
      chk($sformatf("bp.cnt%0d", i), 64'(count), 64'(3 - i));
      chk($sformatf("bp.rdy%0d", i), 64'(in_ready), 64'd1);
    end
    out_ready = 1'b0;
    chk("bp.empty", 64'(out_valid), 64'd0);

    // illegal then flush
    offer(32'hE800_0000, 5'd6);
    chk("ill.flag", 64'(out_illegal), 64'd1);
    chk("ill.fmt", 64'(out_fmt), 64'd0);
    chk("ill.len64", 64'(out_len64), 64'd0);
    chk("ill.inst", out_inst, 64'h0000_0000_E800_0000);
    offer(32'h7E00_0200, 5'd1);
    offer(32'h8000_0001, 5'd1);
    chk("fl.pre.count", 64'(count), 64'd3);
    in_valid = 1'b1;
    in_dword = 32'h8000_0005;
    in_wf    = 5'd2;
    flush    = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl.in_ready", 64'(in_ready), 64'd0);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fl.count", 64'(count), 64'd0);
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.frag", 64'(err_frag), 64'd0);
    step();
    chk("fl.not_taken", 64'(count), 64'd0);

    // async reset mid-assembly
    offer(32'h7E00_0200, 5'd7);
    offer(32'h8000_0002, 5'd7);
    offer(32'hDC50_0000, 5'd7);
    chk("ar.pre.count", 64'(count), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("ar");
    #2;
    reset_n = 1'b1;
    step();
    offer(32'h7E00_0300, 5'd7);
    chk("ar.post.count", 64'(count), 64'd1);
    chk("ar.post.len64", 64'(out_len64), 64'd0);
    chk("ar.post.inst", out_inst, 64'h0000_0000_7E00_0300);
    chk("ar.post.fmt", 64'(out_fmt), 64'h80);
    chk("ar.post.frag", 64'(err_frag), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
